// File: rtl/lcd_types.sv
// Shared LCD types: rectangle-fill FSM states, panel resolution and
// controller command codes.
package lcd_types;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SEQ   = 3'd2,
    WAIT  = 3'd3,
    PIX   = 3'd4,
    PWAIT = 3'd5,
    FIN   = 3'd6
  } fill_state_e;

  localparam logic [15:0] H_RES     = 16'd480;
  localparam logic [15:0] V_RES     = 16'd800;

  localparam logic [15:0] CMD_CASET = 16'h2A00;
  localparam logic [15:0] CMD_PASET = 16'h2B00;
  localparam logic [15:0] CMD_RAMWR = 16'h2C00;

  // Index of the final (RAMWR) entry in the 17-word window-setup sequence.
  localparam logic [4:0]  SEQ_LAST  = 5'd16;

endpackage

// File: rtl/lcd_rect_fill.sv
// Rectangle fill engine: validates a rectangle, programs the column/page
// window with 17 command/data writes, then streams one colour word per pixel.
// Writes are handshaked with an LCD interface via we_o / if_write_ok_i.
module lcd_rect_fill
  import lcd_types::*;
(
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] x0_i,
  input  logic [15:0] x1_i,
  input  logic [15:0] y0_i,
  input  logic [15:0] y1_i,
  input  logic [15:0] color_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        aborted_o,
  output logic        we_o,
  output logic        wr_o,
  output logic        lcd_rs_o,
  output logic [15:0] data_o,
  input  logic        if_busy_i,
  input  logic        if_write_ok_i
);

  fill_state_e state_q;
  logic [15:0] x0_q, x1_q, y0_q, y1_q, color_q;
  logic [4:0]  idx_q;
  logic [19:0] pix_cnt_q;
  logic        abort_q;
  logic        busy_q, done_q, err_q, aborted_q;
  logic        we_q, rs_q;
  logic [15:0] data_q;

  logic [15:0] seq_data_d;
  logic        seq_rs_d;
  logic [15:0] coord_a_d, coord_b_d;
  logic [19:0] pix_total_d;
  logic        rect_ok_d;
  logic        abort_seen_d;

  // Decode the sequence index into the command/data word and its RS level.
  always_comb begin
    seq_data_d = 16'd0;
    seq_rs_d   = 1'b0;
    coord_a_d  = idx_q[3] ? y0_q : x0_q;
    coord_b_d  = idx_q[3] ? y1_q : x1_q;
    if (idx_q[4]) begin
      seq_data_d = CMD_RAMWR;
      seq_rs_d   = 1'b0;
    end else if (!idx_q[0]) begin
      seq_data_d = (idx_q[3] ? CMD_PASET : CMD_CASET) + {14'd0, idx_q[2:1]};
      seq_rs_d   = 1'b0;
    end else begin
      seq_rs_d = 1'b1;
      case (idx_q[2:1])
        2'd0:    seq_data_d = {8'd0, coord_a_d[15:8]};
        2'd1:    seq_data_d = {8'd0, coord_a_d[7:0]};
        2'd2:    seq_data_d = {8'd0, coord_b_d[15:8]};
        2'd3:    seq_data_d = {8'd0, coord_b_d[7:0]};
        default: seq_data_d = 16'd0;
      endcase
    end
  end

  // Rectangle validity, pixel total (only meaningful once valid) and abort view.
  always_comb begin
    rect_ok_d    = (x0_q <= x1_q) && (y0_q <= y1_q) && (x1_q < H_RES) && (y1_q < V_RES);
    pix_total_d  = {10'd0, (x1_q[9:0] - x0_q[9:0] + 10'd1)} *
                   {10'd0, (y1_q[9:0] - y0_q[9:0] + 10'd1)};
    abort_seen_d = abort_q | abort_i;
  end

  // Fill FSM with registered handshake and status outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x0_q      <= 16'd0;
      x1_q      <= 16'd0;
      y0_q      <= 16'd0;
      y1_q      <= 16'd0;
      color_q   <= 16'd0;
      idx_q     <= 5'd0;
      pix_cnt_q <= 20'd0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      we_q      <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 16'd0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      // Remember an abort request until the next write boundary.
      if ((state_q != IDLE) && abort_i) begin
        abort_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          err_q     <= 1'b0;
          aborted_q <= 1'b0;
          abort_q   <= 1'b0;
          if (start_i) begin
            x0_q    <= x0_i;
            x1_q    <= x1_i;
            y0_q    <= y0_i;
            y1_q    <= y1_i;
            color_q <= color_i;
            idx_q   <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!rect_ok_d) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (abort_seen_d) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= FIN;
          end else begin
            state_q <= SEQ;
          end
        end
        SEQ: begin
          if (abort_seen_d) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= FIN;
          end else if (!if_busy_i) begin
            we_q    <= 1'b1;
            data_q  <= seq_data_d;
            rs_q    <= seq_rs_d;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (if_write_ok_i) begin
            if (abort_seen_d) begin
              aborted_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= FIN;
            end else if (idx_q == SEQ_LAST) begin
              pix_cnt_q <= pix_total_d;
              state_q   <= PIX;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= SEQ;
            end
          end
        end
        PIX: begin
          if (abort_seen_d) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= FIN;
          end else if (pix_cnt_q == 20'd0) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (!if_busy_i) begin
            we_q    <= 1'b1;
            data_q  <= color_q;
            rs_q    <= 1'b1;
            state_q <= PWAIT;
          end
        end
        PWAIT: begin
          if (if_write_ok_i) begin
            // Saturating decrement: the counter never wraps below zero.
            if (pix_cnt_q != 20'd0) begin
              pix_cnt_q <= pix_cnt_q - 20'd1;
            end
            if (abort_seen_d) begin
              aborted_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= FIN;
            end else if (pix_cnt_q <= 20'd1) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              state_q <= PIX;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign aborted_o = aborted_q;
  assign we_o      = we_q;
  assign wr_o      = 1'b1;
  assign lcd_rs_o  = rs_q;
  assign data_o    = data_q;

endmodule

// File: tb/tb_lcd_rect_fill.sv
// Directed bench for lcd_rect_fill with an LCD interface model that returns
// if_write_ok_i three cycles after each we_o strobe.
module tb_lcd_rect_fill;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        if_busy_i = 1'b0;
  logic        ok_resp = 1'b0;
  logic        ok_spur = 1'b0;
  logic        ok_w;
  logic [15:0] x0_i = 16'd0, x1_i = 16'd0, y0_i = 16'd0, y1_i = 16'd0, color_i = 16'd0;
  logic        busy_o, done_o, err_o, aborted_o, we_o, wr_o, lcd_rs_o;
  logic [15:0] data_o;

  assign ok_w = ok_resp | ok_spur;

  always #10 pclk = ~pclk;

  lcd_rect_fill dut (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .x0_i         (x0_i),
    .x1_i         (x1_i),
    .y0_i         (y0_i),
    .y1_i         (y1_i),
    .color_i      (color_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .aborted_o    (aborted_o),
    .we_o         (we_o),
    .wr_o         (wr_o),
    .lcd_rs_o     (lcd_rs_o),
    .data_o       (data_o),
    .if_busy_i    (if_busy_i),
    .if_write_ok_i(ok_w)
  );

  // Write log and status capture, sampled on the falling edge.
  logic [15:0] log_data [0:255];
  logic        log_rs   [0:255];
  int          we_cnt = 0;
  int          done_cnt = 0;
  int          unstable_cnt = 0;
  logic        last_err = 1'b0, last_abt = 1'b0;
  logic        pend = 1'b0;
  logic [15:0] pend_data = 16'd0;
  logic        pend_rs = 1'b0;

  // Record every strobe, check hold stability until the acknowledge, count done pulses.
  always @(negedge pclk) begin
    if (we_o === 1'b1) begin
      log_data[we_cnt[7:0]] <= data_o;
      log_rs[we_cnt[7:0]]   <= lcd_rs_o;
      we_cnt    <= we_cnt + 1;
      pend      <= 1'b1;
      pend_data <= data_o;
      pend_rs   <= lcd_rs_o;
    end else if (pend && rst_n) begin
      if ((data_o !== pend_data) || (lcd_rs_o !== pend_rs)) unstable_cnt <= unstable_cnt + 1;
      if (ok_w) pend <= 1'b0;
    end else begin
      pend <= 1'b0;
    end
    if (done_o === 1'b1) begin
      done_cnt <= done_cnt + 1;
      last_err <= err_o;
      last_abt <= aborted_o;
    end
  end

  // LCD interface model: acknowledge three cycles after each strobe.
  initial begin
    forever begin
      @(negedge pclk);
      if (we_o === 1'b1) begin
        repeat (2) @(posedge pclk);
        #1 ok_resp = 1'b1;
        @(posedge pclk);
        #1 ok_resp = 1'b0;
      end
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [15:0] exp_seq [0:16] = '{16'h2A00, 16'h0000, 16'h2A01, 16'h000A,
                                  16'h2A02, 16'h0000, 16'h2A03, 16'h000C,
                                  16'h2B00, 16'h0000, 16'h2B01, 16'h0014,
                                  16'h2B02, 16'h0000, 16'h2B03, 16'h0015,
                                  16'h2C00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lg(input int i);
    return log_data[i[7:0]];
  endfunction

  function automatic logic lr(input int i);
    return log_rs[i[7:0]];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
    #1;
  endtask

  task automatic go(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                    input logic [15:0] d, input logic [15:0] col);
    x0_i = a; y0_i = b; x1_i = c; y1_i = d; color_i = col;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_we(input int target, input int budget, input string tag);
    int k = 0;
    while ((we_cnt < target) && (k < budget)) begin
      tick(1);
      k++;
    end
    check(tag, 32'(we_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int prev, input int budget, input string tag);
    int k = 0;
    while ((done_cnt <= prev) && (k < budget)) begin
      tick(1);
      k++;
    end
    check(tag, 32'(done_cnt > prev), 32'd1);
  endtask

  int base, d0;

  initial begin
    // Reset values
    tick(3);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_wr", 32'(wr_o), 32'd1);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_rs", 32'(lcd_rs_o), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1x1 rectangle at origin, red
    base = we_cnt; d0 = done_cnt;
    go(16'd0, 16'd0, 16'd0, 16'd0, 16'hF800);
    wait_done(d0, 400, "a_done_timeout");
    tick(3);
    check("a_we_count", 32'(we_cnt - base), 32'd18);
    check("a_first_cmd", 32'(lg(base)), 32'h2A00);
    check("a_first_rs", 32'(lr(base)), 32'd0);
    check("a_ramwr", 32'(lg(base + 16)), 32'h2C00);
    check("a_pixel", 32'(lg(base + 17)), 32'hF800);
    check("a_pixel_rs", 32'(lr(base + 17)), 32'd1);
    check("a_done_once", 32'(done_cnt - d0), 32'd1);
    check("a_err", 32'(last_err), 32'd0);
    check("a_busy_after", 32'(busy_o), 32'd0);

    // (10,20)-(12,21): window words and 6 pixels
    base = we_cnt; d0 = done_cnt;
    go(16'd10, 16'd20, 16'd12, 16'd21, 16'h1234);
    wait_done(d0, 600, "b_done_timeout");
    tick(3);
    check("b_we_count", 32'(we_cnt - base), 32'd23);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("b_seq%0d", i), 32'(lg(base + i)), 32'(exp_seq[i]));
      check($sformatf("b_rs%0d", i), 32'(lr(base + i)), (i < 16) ? 32'(i % 2) : 32'd0);
    end
    for (int i = 17; i < 23; i++) begin
      check($sformatf("b_pix%0d", i - 17), 32'(lg(base + i)), 32'h1234);
    end
    check("b_err", 32'(last_err), 32'd0);

    // Invalid: x0 > x1
    base = we_cnt;
    go(16'd5, 16'd0, 16'd4, 16'd0, 16'h0001);
    check("c_busy_check", 32'(busy_o), 32'd1);
    check("c_done_early", 32'(done_o), 32'd0);
    tick(1);
    check("c_done", 32'(done_o), 32'd1);
    check("c_err", 32'(err_o), 32'd1);
    check("c_aborted", 32'(aborted_o), 32'd0);
    tick(1);
    check("c_idle_busy", 32'(busy_o), 32'd0);
    tick(5);
    check("c_no_we", 32'(we_cnt - base), 32'd0);

    // Invalid: x1 at horizontal resolution
    base = we_cnt;
    go(16'd0, 16'd0, 16'd480, 16'd0, 16'h0002);
    tick(1);
    check("d_done", 32'(done_o), 32'd1);
    check("d_err", 32'(err_o), 32'd1);
    tick(6);
    check("d_no_we", 32'(we_cnt - base), 32'd0);

    // Abort during 3rd pixel of a 10x10 fill; start while busy is ignored
    base = we_cnt; d0 = done_cnt;
    go(16'd0, 16'd0, 16'd9, 16'd9, 16'h07E0);
    wait_we(base + 20, 600, "e_third_pixel_timeout");
    abort_i = 1'b1;
    start_i = 1'b1;
    x0_i = 16'd1;
    tick(1);
    abort_i = 1'b0;
    start_i = 1'b0;
    wait_done(d0, 100, "e_done_timeout");
    tick(20);
    check("e_we_count", 32'(we_cnt - base), 32'd20);
    check("e_third_pix", 32'(lg(base + 19)), 32'h07E0);
    check("e_aborted", 32'(last_abt), 32'd1);
    check("e_err", 32'(last_err), 32'd0);
    check("e_done_once", 32'(done_cnt - d0), 32'd1);
    check("e_busy_after", 32'(busy_o), 32'd0);

    // Reset during SEQ, then a clean restart
    base = we_cnt;
    go(16'd0, 16'd0, 16'd0, 16'd0, 16'h001F);
    wait_we(base + 4, 100, "f_seq_timeout");
    tick(1);
    rst_n = 1'b0;
    #1;
    check("f_rst_we", 32'(we_o), 32'd0);
    check("f_rst_busy", 32'(busy_o), 32'd0);
    check("f_rst_rs", 32'(lcd_rs_o), 32'd0);
    check("f_rst_data", 32'(data_o), 32'd0);
    check("f_rst_status", 32'({done_o, err_o, aborted_o}), 32'd0);
    check("f_rst_wr", 32'(wr_o), 32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    base = we_cnt; d0 = done_cnt;
    go(16'd0, 16'd0, 16'd0, 16'd0, 16'h001F);
    wait_done(d0, 400, "f_done_timeout");
    tick(3);
    check("f_we_count", 32'(we_cnt - base), 32'd18);
    check("f_first_cmd", 32'(lg(base)), 32'h2A00);
    check("f_pixel", 32'(lg(base + 17)), 32'h001F);
    check("f_aborted", 32'(last_abt), 32'd0);

    // Spurious acknowledge in IDLE, then interface busy for 50 cycles
    base = we_cnt;
    ok_spur = 1'b1;
    tick(1);
    ok_spur = 1'b0;
    tick(2);
    check("g_spur_busy", 32'(busy_o), 32'd0);
    check("g_spur_we", 32'(we_cnt - base), 32'd0);
    if_busy_i = 1'b1;
    d0 = done_cnt;
    go(16'd1, 16'd2, 16'd1, 16'd2, 16'hAAAA);
    tick(49);
    check("g_no_we_busy", 32'(we_cnt - base), 32'd0);
    check("g_still_busy", 32'(busy_o), 32'd1);
    if_busy_i = 1'b0;
    wait_done(d0, 400, "g_done_timeout");
    tick(3);
    check("g_we_count", 32'(we_cnt - base), 32'd18);
    check("g_first_cmd", 32'(lg(base)), 32'h2A00);
    check("g_x0_lo", 32'(lg(base + 3)), 32'h0001);
    check("g_pixel", 32'(lg(base + 17)), 32'hAAAA);
    check("g_done_once", 32'(done_cnt - d0), 32'd1);

    check("hold_stable", 32'(unstable_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
